// File: rtl/systolic_scheduler.sv
// systolic_scheduler: sequences a 2x2 output-stationary systolic multiplier.
// Latches A and B on start, clears the PEs, feeds skewed operands onto the
// west/north edges over three feed steps, drains for one step, then holds
// DONE so the result can be read from the PEs on the display path.
//
// Handshake: start is a one-cycle request, accepted only in IDLE or DONE;
// pe_en and pe_clear are one-cycle strobes to the array, never together.
// A step advances when (fast | step_tick) is high on the clock edge; abort
// overrides everything and returns to IDLE without touching the PEs.
module systolic_scheduler #(
  parameter int DATA_W     = 8,
  parameter int STEP_CNT_W = 3
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  fast,
  input  logic                  step_tick,
  input  logic [DATA_W-1:0]     a11,
  input  logic [DATA_W-1:0]     a12,
  input  logic [DATA_W-1:0]     a21,
  input  logic [DATA_W-1:0]     a22,
  input  logic [DATA_W-1:0]     b11,
  input  logic [DATA_W-1:0]     b12,
  input  logic [DATA_W-1:0]     b21,
  input  logic [DATA_W-1:0]     b22,
  output logic [DATA_W-1:0]     a_row1,
  output logic [DATA_W-1:0]     a_row2,
  output logic [DATA_W-1:0]     b_col1,
  output logic [DATA_W-1:0]     b_col2,
  output logic                  pe_en,
  output logic                  pe_clear,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED0 = 3'd2,
    S_FEED1 = 3'd3,
    S_FEED2 = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_adv;
  logic w_step_state;

  logic [DATA_W-1:0] r_a11, r_a12, r_a21, r_a22;
  logic [DATA_W-1:0] r_b11, r_b12, r_b21, r_b22;
  logic [DATA_W-1:0] r_a_row1, r_a_row2, r_b_col1, r_b_col2;
  logic [STEP_CNT_W-1:0] r_step_count;

  assign w_adv        = fast | step_tick;
  assign w_step_state = (r_state == S_FEED0) || (r_state == S_FEED1) ||
                        (r_state == S_FEED2) || (r_state == S_DRAIN);

  // State register
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort wins over every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_FEED0;
      S_FEED0: if (w_adv) w_next = S_FEED1;
      S_FEED1: if (w_adv) w_next = S_FEED2;
      S_FEED2: if (w_adv) w_next = S_DRAIN;
      S_DRAIN: if (w_adv) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Output decode; strobes are suppressed in the cycle abort is sampled
  always_comb begin
    pe_clear = 1'b0;
    pe_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (r_state == S_CLEAR) pe_clear = ~abort;
    if (w_step_state)       pe_en    = w_adv & ~abort;
    busy = (r_state == S_CLEAR) || w_step_state;
    done = (r_state == S_DONE);
  end

  // Operand latches: captured only when a run is accepted
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      r_a11 <= '0; r_a12 <= '0; r_a21 <= '0; r_a22 <= '0;
      r_b11 <= '0; r_b12 <= '0; r_b21 <= '0; r_b22 <= '0;
    end else if (w_next == S_CLEAR) begin
      r_a11 <= a11; r_a12 <= a12; r_a21 <= a21; r_a22 <= a22;
      r_b11 <= b11; r_b12 <= b12; r_b21 <= b21; r_b22 <= b22;
    end
  end

  // Edge operands are launched on state entry and held for the whole state
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      r_a_row1 <= '0; r_a_row2 <= '0; r_b_col1 <= '0; r_b_col2 <= '0;
    end else begin
      r_a_row1 <= '0; r_a_row2 <= '0; r_b_col1 <= '0; r_b_col2 <= '0;
      case (w_next)
        S_FEED0: begin
          r_a_row1 <= r_a11;
          r_b_col1 <= r_b11;
        end
        S_FEED1: begin
          r_a_row1 <= r_a12;
          r_a_row2 <= r_a21;
          r_b_col1 <= r_b21;
          r_b_col2 <= r_b12;
        end
        S_FEED2: begin
          r_a_row2 <= r_a22;
          r_b_col2 <= r_b22;
        end
        default: ;
      endcase
    end
  end

  // Step counter: zeroed around CLEAR and on abort, counts issued pe_en
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset)
      r_step_count <= '0;
    else if (abort || (w_next == S_CLEAR) || (r_state == S_CLEAR))
      r_step_count <= '0;
    else if (pe_en)
      r_step_count <= r_step_count + 1'b1;
  end

  assign a_row1     = r_a_row1;
  assign a_row2     = r_a_row2;
  assign b_col1     = r_b_col1;
  assign b_col2     = r_b_col2;
  assign step_count = r_step_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler: directed bench for systolic_scheduler with a
// behavioural 2x2 output-stationary PE array driven from the DUT outputs.
module tb_systolic_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start, abort, fast, step_tick;
  logic [7:0] a11, a12, a21, a22, b11, b12, b21, b22;
  logic [7:0] a_row1, a_row2, b_col1, b_col2;
  logic       pe_en, pe_clear, busy, done;
  logic [2:0] step_count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // PE array model
  logic [31:0] acc11, acc12, acc21, acc22;
  logic [7:0]  m_a11r, m_a21r, m_b11r, m_b12r;

  systolic_scheduler #(.DATA_W(8), .STEP_CNT_W(3)) dut (
    .clock_100Mhz(clk), .reset(rst_n),
    .start(start), .abort(abort), .fast(fast), .step_tick(step_tick),
    .a11(a11), .a12(a12), .a21(a21), .a22(a22),
    .b11(b11), .b12(b12), .b21(b21), .b22(b22),
    .a_row1(a_row1), .a_row2(a_row2), .b_col1(b_col1), .b_col2(b_col2),
    .pe_en(pe_en), .pe_clear(pe_clear), .busy(busy), .done(done),
    .step_count(step_count), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE model: samples the strobes and edges that the next posedge will see
  always begin
    @(negedge clk);
    #2;
    if (pe_clear) begin
      acc11 = 0; acc12 = 0; acc21 = 0; acc22 = 0;
      m_a11r = 0; m_a21r = 0; m_b11r = 0; m_b12r = 0;
    end else if (pe_en) begin
      acc11 = acc11 + a_row1 * b_col1;
      acc12 = acc12 + m_a11r * b_col2;
      acc21 = acc21 + a_row2 * m_b11r;
      acc22 = acc22 + m_a21r * m_b12r;
      m_a11r = a_row1; m_a21r = a_row2;
      m_b11r = b_col1; m_b12r = b_col2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic t);
    @(negedge clk);
    start = s;
    step_tick = t;
    #1;
  endtask

  task automatic check_edges(input string tag, input int r1, input int r2, input int c1, input int c2);
    check({tag, ".a_row1"}, a_row1, r1);
    check({tag, ".a_row2"}, a_row2, r2);
    check({tag, ".b_col1"}, b_col1, c1);
    check({tag, ".b_col2"}, b_col2, c2);
  endtask

  task automatic set_ab(input int x11, x12, x21, x22, y11, y12, y21, y22);
    a11 = x11; a12 = x12; a21 = x21; a22 = x22;
    b11 = y11; b12 = y12; b21 = y21; b22 = y22;
  endtask

  task automatic check_c(input string tag, input int c11, c12, c21, c22);
    check({tag, ".c11"}, acc11, c11);
    check({tag, ".c12"}, acc12, c12);
    check({tag, ".c21"}, acc21, c21);
    check({tag, ".c22"}, acc22, c22);
  endtask

  int exp_r1[4] = '{1, 2, 0, 0};
  int exp_r2[4] = '{0, 3, 4, 0};
  int exp_c1[4] = '{5, 7, 0, 0};
  int exp_c2[4] = '{0, 6, 8, 0};

  initial begin
    int ticks, en_cnt, bad;
    logic t;
    rst_n = 1'b0; start = 0; abort = 0; fast = 1; step_tick = 0;
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    acc11 = 0; acc12 = 0; acc21 = 0; acc22 = 0;
    m_a11r = 0; m_a21r = 0; m_b11r = 0; m_b12r = 0;

    // Reset state
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pe_en", pe_en, 0);
    check("rst.sc", step_count, 0);
    check_edges("rst", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Test 1: fast run, A=[1 2;3 4], B=[5 6;7 8]
    cyc(1, 0);
    check("t1.idle_busy", busy, 0);
    cyc(0, 0);
    check("t1.clear", pe_clear, 1);
    check("t1.clear_en", pe_en, 0);
    check("t1.clear_busy", busy, 1);
    cyc(0, 0);
    check("t1.f0_en", pe_en, 1);
    check("t1.f0_sc", step_count, 0);
    check_edges("t1.f0", 1, 0, 5, 0);
    cyc(0, 0);
    check("t1.f1_en", pe_en, 1);
    check("t1.f1_sc", step_count, 1);
    check_edges("t1.f1", 2, 3, 7, 6);
    cyc(0, 0);
    check("t1.f2_en", pe_en, 1);
    check("t1.f2_sc", step_count, 2);
    check_edges("t1.f2", 0, 4, 0, 8);
    cyc(0, 0);
    check("t1.dr_en", pe_en, 1);
    check("t1.dr_sc", step_count, 3);
    check_edges("t1.dr", 0, 0, 0, 0);
    cyc(0, 0);
    check("t1.done", done, 1);
    check("t1.done_busy", busy, 0);
    check("t1.done_en", pe_en, 0);
    check("t1.done_sc", step_count, 4);
    check_c("t1", 19, 22, 43, 50);
    cyc(0, 1);
    check("t1.done_tick_en", pe_en, 0);

    // Test 2: slow run, tick every 10 cycles
    fast = 0;
    cyc(1, 0);
    cyc(0, 0);
    check("t2.clear", pe_clear, 1);
    ticks = 0; en_cnt = 0; bad = 0;
    for (int k = 0; k < 45; k++) begin
      t = ((k % 10) == 9);
      cyc(0, t);
      if (ticks < 4) begin
        if (a_row1 !== exp_r1[ticks] || a_row2 !== exp_r2[ticks] ||
            b_col1 !== exp_c1[ticks] || b_col2 !== exp_c2[ticks]) bad++;
      end
      if (pe_en) en_cnt++;
      if (pe_en !== (t && ticks < 4)) bad++;
      if (t) ticks++;
    end
    check("t2.hold_and_strobe", bad, 0);
    check("t2.en_count", en_cnt, 4);
    check("t2.done", done, 1);
    check("t2.sc", step_count, 4);
    check_c("t2", 19, 22, 43, 50);

    // Test 3: start mid-run ignored, A input change not used
    fast = 1;
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 0);
    a11 = 9;
    check("t3.f1_sc", step_count, 1);
    cyc(0, 0);
    check("t3.no_restart_clear", pe_clear, 0);
    check("t3.f2_sc", step_count, 2);
    check_edges("t3.f2", 0, 4, 0, 8);
    cyc(0, 0);
    cyc(0, 0);
    check("t3.done", done, 1);
    check_c("t3", 19, 22, 43, 50);
    a11 = 1;

    // Test 4: abort during FEED2, then a clean run
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(0, 0);
    abort = 1; #1;
    check("t4.abort_en", pe_en, 0);
    cyc(0, 0);
    abort = 0; #1;
    check("t4.idle_busy", busy, 0);
    check("t4.idle_done", done, 0);
    check("t4.idle_en", pe_en, 0);
    check("t4.idle_sc", step_count, 0);
    check_edges("t4.idle", 0, 0, 0, 0);
    cyc(1, 0);
    cyc(0, 0);
    check("t4.clear", pe_clear, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0);
    cyc(0, 0);
    check("t4.done", done, 1);
    check_c("t4", 19, 22, 43, 50);

    // Test 5: all 255
    set_ab(255, 255, 255, 255, 255, 255, 255, 255);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    check_edges("t5.f0", 255, 0, 255, 0);
    cyc(0, 0);
    check_edges("t5.f1", 255, 255, 255, 255);
    cyc(0, 0);
    check_edges("t5.f2", 0, 255, 0, 255);
    cyc(0, 0);
    cyc(0, 0);
    check("t5.done", done, 1);
    check_c("t5", 130050, 130050, 130050, 130050);

    // Test 6: async reset mid-DRAIN, ticks ignored, start+tick in IDLE
    set_ab(1, 2, 3, 4, 5, 6, 7, 8);
    fast = 0;
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    cyc(0, 1);
    cyc(0, 1);
    cyc(0, 0);
    check("t6.drain_sc", step_count, 3);
    rst_n = 1'b0; #1;
    check("t6.rst_busy", busy, 0);
    check("t6.rst_sc", step_count, 0);
    check("t6.rst_done", done, 0);
    check_edges("t6.rst", 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(0, 1);
    cyc(0, 1);
    check("t6.tick_idle_busy", busy, 0);
    check("t6.tick_idle_en", pe_en, 0);
    cyc(1, 1);
    cyc(0, 0);
    check("t6.clear", pe_clear, 1);
    check("t6.clear_sc", step_count, 0);
    cyc(0, 0);
    check("t6.f0_sc", step_count, 0);
    check_edges("t6.f0", 1, 0, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_scheduler.md
Name: systolic_scheduler

Overview:
- Sequences a 2x2 output-stationary systolic multiplier (C = A x B, 8-bit entries) whose PE, shift and count registers are shown on the seven-segment display path.
- On start it latches both matrices, clears the PEs, drives skewed operands onto the west and north array edges one step at a time, drains the array, then holds the result for display.
- Steps advance on a tick from the second counter, or on every clock in fast mode, so a run can be watched step by step on the display.

Parameters:
DATA_W, 8, width of each matrix entry and edge operand
STEP_CNT_W, 3, width of step_count output

Ports:
clock_100Mhz  input  1  system clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a run when idle or done
abort  input  1  level; forces return to IDLE
fast  input  1  1 = advance every clock; 0 = advance on step_tick
step_tick  input  1  one-cycle advance pulse (from second counter)
a11,a12,a21,a22  input  DATA_W  matrix A entries
b11,b12,b21,b22  input  DATA_W  matrix B entries
a_row1,a_row2  output  DATA_W  west-edge operands, rows 1/2
b_col1,b_col2  output  DATA_W  north-edge operands, columns 1/2
pe_en  output  1  one-cycle strobe; PEs capture/accumulate/shift
pe_clear  output  1  one-cycle strobe; PEs zero accumulators and pipe regs
busy  output  1  high in CLEAR, FEED0-2, DRAIN
done  output  1  high in DONE; result valid in PEs
step_count  output  STEP_CNT_W  steps issued this run (0..4)

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; operand latches 0.
- Advance condition: adv = fast | step_tick, sampled on the clock edge.
- States and transitions:
  - IDLE: start -> latch A and B -> CLEAR.
  - DONE: start -> latch A and B -> CLEAR. Otherwise hold DONE with done=1.
  - CLEAR: pe_clear=1 for exactly one cycle; step_count<=0; next FEED0 unconditionally (no adv needed).
  - FEED0 / FEED1 / FEED2 / DRAIN: edge operands are held stable for the whole state. On adv: pe_en=1 for that one cycle, step_count increments, state moves on (FEED0->FEED1->FEED2->DRAIN->DONE).
- Edge operands per state (registered, launched on entry; values use the latched copies):
  - FEED0: a_row1=a11, a_row2=0, b_col1=b11, b_col2=0.
  - FEED1: a_row1=a12, a_row2=a21, b_col1=b21, b_col2=b12.
  - FEED2: a_row1=0, a_row2=a22, b_col1=0, b_col2=b22.
  - DRAIN, DONE, IDLE, CLEAR: all four edges = 0.
- Latency:
  - fast=1: start -> done is 6 cycles (CLEAR + 4 steps + DONE entry).
  - fast=0: the 4 steps consume 4 step_ticks.
- After the 4th pe_en the array holds C11=a11b11+a12b21, C12=a11b12+a12b22, C21=a21b11+a22b21, C22=a21b12+a22b22.
- step_count reads 4 in DONE and holds until the next CLEAR.
- pe_en and pe_clear are never high in the same cycle.
- Exactly one pe_en is issued per step state; a step_tick seen in IDLE, CLEAR or DONE is ignored.
- start while busy is ignored; latched operands do not change mid-run, even if A/B inputs change.
- start and step_tick in the same cycle in IDLE: the run starts; the tick is not counted.
- abort has priority over everything; the edge sampling abort=1 gives state=IDLE, all outputs 0, and no pe_en or pe_clear that cycle. The PE contents are left as is.
- Asynchronous reset asserted mid-run gives the IDLE values immediately; after release the block waits for a new start.

Test Plan:
- fast=1, A=[1 2;3 4], B=[5 6;7 8], start -> pe_clear at cycle 1; pe_en in 4 consecutive cycles; edges match the FEED table; done at cycle 6; model PEs give C=[19 22;43 50]; step_count=4.
- fast=0, same A and B, ticks every 10 cycles -> each edge value is held for 10 cycles; exactly 4 pe_en, each coincident with a tick; done after the 4th tick.
- Apply start in FEED1, then change a11 to 9 -> no restart; edges still use the latched a11=1; C11=19.
- Assert abort during FEED2 -> next edge gives IDLE, all outputs 0, no further pe_en; a following start runs a clean full sequence.
- A=B=all 255, fast=1 -> edges carry 255 in the correct slots; model C entries = 130050 (PE accumulators ≥17 bits); done=1.
- Drop reset to 0 asynchronously mid-DRAIN -> outputs 0 without waiting for a clock edge; ticks after release are ignored until start; tick and start together in IDLE -> run starts with step_count=0.
